// File: rtl/exu_regfile_mp.sv
// rtl/exu_regfile_mp.sv - multi-port EXU register file with write-to-read bypass and busy scoreboard
//
// Ports:
//   clk, rst      clock; synchronous active-high reset clears all registers and busy bits
//   read_idx      NUM_RD packed read indices (port p at [p*RFIDX_WIDTH +: RFIDX_WIDTH])
//   read_data     NUM_RD packed combinational read results (port p at [p*XLEN +: XLEN])
//   read_busy     per read port: the addressed register still waits for a producer
//   wbck_ena      per writeback port enable
//   wbck_idx      NUM_WR packed writeback destination indices
//   wbck_data     NUM_WR packed writeback data
//   sb_set_ena    mark sb_set_idx busy from the next cycle
//   sb_set_idx    register index to mark busy
//   x1_data       stored x1 value, never bypassed
module exu_regfile_mp #(
    parameter int XLEN        = 32,
    parameter int RFREG_NUM   = 32,
    parameter int RFIDX_WIDTH = 5,
    parameter int NUM_RD      = 2,
    parameter int NUM_WR      = 2,
    parameter int BYPASS      = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_RD*RFIDX_WIDTH-1:0] read_idx,
    output logic [NUM_RD*XLEN-1:0]        read_data,
    output logic [NUM_RD-1:0]             read_busy,
    input  logic [NUM_WR-1:0]             wbck_ena,
    input  logic [NUM_WR*RFIDX_WIDTH-1:0] wbck_idx,
    input  logic [NUM_WR*XLEN-1:0]        wbck_data,
    input  logic                          sb_set_ena,
    input  logic [RFIDX_WIDTH-1:0]        sb_set_idx,
    output logic [XLEN-1:0]               x1_data
);

    localparam logic [RFIDX_WIDTH:0] REG_LIMIT = (RFIDX_WIDTH+1)'(RFREG_NUM);

    // x0 and indices past the implemented registers are never stored nor busy.
    function automatic logic idx_ok(input logic [RFIDX_WIDTH-1:0] idx);
        return (idx != '0) && ({1'b0, idx} < REG_LIMIT);
    endfunction

    logic [XLEN-1:0]      regs_q [RFREG_NUM];
    logic [RFREG_NUM-1:0] busy_q;
    logic [RFREG_NUM-1:0] busy_d;
    logic [NUM_WR-1:0]    wr_ok;
    logic                 set_ok;

    always_comb begin
        wr_ok = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wr_ok[w] = wbck_ena[w] & idx_ok(wbck_idx[w*RFIDX_WIDTH +: RFIDX_WIDTH]);
        end
    end

    assign set_ok = sb_set_ena & idx_ok(sb_set_idx);

    // A writeback retires the producer; a set in the same cycle is a new
    // producer for that register, so the set is applied last and wins.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < RFREG_NUM; r++) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_ok[w] && (wbck_idx[w*RFIDX_WIDTH +: RFIDX_WIDTH] == RFIDX_WIDTH'(r))) begin
                    busy_d[r] = 1'b0;
                end
            end
            if (set_ok && (sb_set_idx == RFIDX_WIDTH'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Ports are scanned in ascending order so the highest-numbered
    // colliding port's assignment is the one that lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < RFREG_NUM; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
            for (int r = 1; r < RFREG_NUM; r++) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_ok[w] && (wbck_idx[w*RFIDX_WIDTH +: RFIDX_WIDTH] == RFIDX_WIDTH'(r))) begin
                        regs_q[r] <= wbck_data[w*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    always_comb begin
        read_data = '0;
        read_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (idx_ok(read_idx[p*RFIDX_WIDTH +: RFIDX_WIDTH])) begin
                read_data[p*XLEN +: XLEN] = regs_q[read_idx[p*RFIDX_WIDTH +: RFIDX_WIDTH]];
                read_busy[p]              = busy_q[read_idx[p*RFIDX_WIDTH +: RFIDX_WIDTH]];
                if (BYPASS != 0) begin
                    for (int w = 0; w < NUM_WR; w++) begin
                        if (wr_ok[w] && (wbck_idx[w*RFIDX_WIDTH +: RFIDX_WIDTH] ==
                                         read_idx[p*RFIDX_WIDTH +: RFIDX_WIDTH])) begin
                            read_data[p*XLEN +: XLEN] = wbck_data[w*XLEN +: XLEN];
                            read_busy[p]              = 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign x1_data = regs_q[1];

endmodule

// File: tb/tb_exu_regfile_mp.sv
// tb/tb_exu_regfile_mp.sv - self-checking bench for exu_regfile_mp with and without bypass
module tb_exu_regfile_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  read_idx = '0;
    logic [1:0]  wbck_ena = '0;
    logic [9:0]  wbck_idx = '0;
    logic [63:0] wbck_data = '0;
    logic        sb_set_ena = 1'b0;
    logic [4:0]  sb_set_idx = '0;

    logic [63:0] rd1, rd0;
    logic [1:0]  busy1, busy0;
    logic [31:0] x1_bp1, x1_bp0;

    int n_err = 0;
    int n_chk = 0;
    bit chk_en = 1'b0;

    logic [31:0] mreg  [32];
    bit          mbusy [32];

    always #5 clk = ~clk;

    exu_regfile_mp #(.BYPASS(1)) u_bp1 (
        .clk(clk), .rst(rst), .read_idx(read_idx), .read_data(rd1), .read_busy(busy1),
        .wbck_ena(wbck_ena), .wbck_idx(wbck_idx), .wbck_data(wbck_data),
        .sb_set_ena(sb_set_ena), .sb_set_idx(sb_set_idx), .x1_data(x1_bp1)
    );

    exu_regfile_mp #(.BYPASS(0)) u_bp0 (
        .clk(clk), .rst(rst), .read_idx(read_idx), .read_data(rd0), .read_busy(busy0),
        .wbck_ena(wbck_ena), .wbck_idx(wbck_idx), .wbck_data(wbck_data),
        .sb_set_ena(sb_set_ena), .sb_set_idx(sb_set_idx), .x1_data(x1_bp0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int widx(input int w);
        return int'(wbck_idx[w*5 +: 5]);
    endfunction

    function automatic int ridx(input int p);
        return int'(read_idx[p*5 +: 5]);
    endfunction

    // Reference read: stored value, overridden by the last enabled writer when bypassing.
    function automatic logic [31:0] m_data(input int idx, input bit bp);
        logic [31:0] v;
        if (idx == 0) return 32'h0;
        v = mreg[idx];
        if (bp) for (int w = 0; w < 2; w++) if (wbck_ena[w] && widx(w) == idx) v = wbck_data[w*32 +: 32];
        return v;
    endfunction

    function automatic logic [31:0] m_busy(input int idx, input bit bp);
        bit b;
        if (idx == 0) return 32'h0;
        b = mbusy[idx];
        if (bp) for (int w = 0; w < 2; w++) if (wbck_ena[w] && widx(w) == idx) b = 1'b0;
        return {31'b0, b};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                mreg[r]  = 32'h0;
                mbusy[r] = 1'b0;
            end
        end else begin
            for (int w = 0; w < 2; w++) begin
                if (wbck_ena[w] && widx(w) != 0) begin
                    mreg[widx(w)]  = wbck_data[w*32 +: 32];
                    mbusy[widx(w)] = 1'b0;
                end
            end
            if (sb_set_ena && sb_set_idx != 0) mbusy[sb_set_idx] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("model_bp1_data%0d", p), rd1[p*32 +: 32], m_data(ridx(p), 1'b1));
                chk($sformatf("model_bp0_data%0d", p), rd0[p*32 +: 32], m_data(ridx(p), 1'b0));
                chk($sformatf("model_bp1_busy%0d", p), {31'b0, busy1[p]}, m_busy(ridx(p), 1'b1));
                chk($sformatf("model_bp0_busy%0d", p), {31'b0, busy0[p]}, m_busy(ridx(p), 1'b0));
            end
            chk("model_bp1_x1", x1_bp1, mreg[1]);
            chk("model_bp0_x1", x1_bp0, mreg[1]);
        end
    end

    task automatic cyc(input bit r, input logic [1:0] ena,
                       input int i0, input logic [31:0] d0, input int i1, input logic [31:0] d1,
                       input bit set, input int sidx, input int r0, input int r1);
        @(posedge clk);
        #1;
        rst        = r;
        wbck_ena   = ena;
        wbck_idx   = {5'(i1), 5'(i0)};
        wbck_data  = {d1, d0};
        sb_set_ena = set;
        sb_set_idx = 5'(sidx);
        read_idx   = {5'(r1), 5'(r0)};
        @(negedge clk);
    endtask

    initial begin
        cyc(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;

        cyc(0, 2'b11, 1, 32'hCAFE, 5, 32'h55, 1, 5, 5, 1);
        chk("wr_bp1_byp_x5", rd1[31:0], 32'h55);
        chk("wr_bp1_byp_x1", rd1[63:32], 32'hCAFE);
        chk("wr_bp0_old_x5", rd0[31:0], 32'h0);
        cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 1);
        chk("wr_bp0_x5", rd0[31:0], 32'h55);
        chk("busy_x5", {31'b0, busy1[0]}, 32'h1);
        chk("x1_stored", x1_bp1, 32'hCAFE);

        cyc(1, 2'b01, 6, 32'h66, 0, 0, 0, 0, 5, 6);
        cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 6);
        chk("rst_data_x5", rd1[31:0], 32'h0);
        chk("rst_data_x6", rd0[63:32], 32'h0);
        chk("rst_busy_x5", {30'b0, busy1}, 32'h0);
        chk("rst_x1_bp1", x1_bp1, 32'h0);
        chk("rst_x1_bp0", x1_bp0, 32'h0);

        cyc(0, 2'b11, 5, 32'hDEADBEEF, 0, 32'h1234, 0, 0, 5, 0);
        chk("byp_deadbeef", rd1[31:0], 32'hDEADBEEF);
        chk("x0_byp", rd1[63:32], 32'h0);
        cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 5);
        chk("deadbeef_p0", rd0[31:0], 32'hDEADBEEF);
        chk("deadbeef_p1", rd0[63:32], 32'hDEADBEEF);
        cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("x0_read", rd1[31:0], 32'h0);

        cyc(0, 2'b11, 7, 32'h11, 7, 32'h22, 0, 0, 7, 7);
        chk("collide_byp", rd1[31:0], 32'h22);
        cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 7);
        chk("collide_stored", rd0[63:32], 32'h22);

        cyc(0, 2'b01, 3, 32'hA5, 0, 0, 0, 0, 3, 1);
        chk("byp_x3_bp1", rd1[31:0], 32'hA5);
        chk("byp_x3_bp0", rd0[31:0], 32'h0);
        chk("byp_x1_untouched", x1_bp1, 32'h0);
        cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 3);
        chk("nobyp_x3_next", rd0[31:0], 32'hA5);

        cyc(0, 2'b00, 0, 0, 0, 0, 1, 9, 9, 9);
        chk("sb_same_cycle", {31'b0, busy1[0]}, 32'h0);
        cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9);
        chk("sb_next_bp1", {31'b0, busy1[0]}, 32'h1);
        chk("sb_next_bp0", {31'b0, busy0[1]}, 32'h1);
        cyc(0, 2'b10, 0, 0, 9, 32'h99, 0, 0, 9, 9);
        chk("sb_clear_bp1", {31'b0, busy1[0]}, 32'h0);
        chk("sb_clear_bp0", {31'b0, busy0[0]}, 32'h1);
        cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9);
        chk("sb_cleared_bp0", {31'b0, busy0[0]}, 32'h0);
        cyc(0, 2'b01, 9, 32'hAB, 0, 0, 1, 9, 9, 9);
        cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9);
        chk("sb_set_wins", {31'b0, busy1[0]}, 32'h1);

        cyc(0, 2'b00, 0, 0, 0, 0, 1, 4, 4, 4);
        cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 4);
        chk("mid_busy_x4", {31'b0, busy0[0]}, 32'h1);
        cyc(1, 2'b01, 4, 32'h44, 0, 0, 0, 0, 4, 4);
        cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 4);
        chk("mid_rst_data", rd1[31:0], 32'h0);
        chk("mid_rst_busy", {30'b0, busy1}, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) == 0, 2'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 9), $urandom,
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 9), $urandom,
                $urandom_range(0, 3) == 0, $urandom_range(0, 9),
                $urandom_range(0, 9), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 9));
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
